// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: state codes, opcode/funct constants and ALU op codes for the multi-cycle MIPS sequencer
package control_sequencer_pkg;
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_RF  = 3'd2,
        S_EX  = 3'd3,
        S_WB  = 3'd4,
        S_OUT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_SLT = 4'd5
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam state_t OUTPUT_REG = S_OUT;

    function automatic alu_op_t funct_alu(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_NOP;
        endcase
    endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction-ROM, run/zero inputs and decoded control outputs of the sequencer
interface control_sequencer_if #(parameter int PC_W = 8);
    logic            run;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic [2:0]      state;
    logic [4:0]      rsource;
    logic [4:0]      rtemp;
    logic [4:0]      rdestination;
    logic [3:0]      alu_op;
    logic            use_imm;
    logic [7:0]      imm;
    logic            wb_en;
    logic            alu_zero;
    logic            halted;

    modport master (
        input  run, imem_data, alu_zero,
        output imem_addr, state, rsource, rtemp, rdestination, alu_op, use_imm, imm, wb_en, halted
    );
    modport slave (
        output run, imem_data, alu_zero,
        input  imem_addr, state, rsource, rtemp, rdestination, alu_op, use_imm, imm, wb_en, halted
    );
endinterface

// File: rtl/control_sequencer_instr_decode.sv
// instr_decode: combinational decode of the held instruction word into register indices and ALU controls
module instr_decode
    import control_sequencer_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  rsource,
    output logic [4:0]  rtemp,
    output logic [4:0]  rdestination,
    output alu_op_t     alu_op,
    output logic        use_imm,
    output logic [7:0]  imm,
    output logic        is_wb,
    output logic        is_beq,
    output logic        is_j,
    output logic        is_halt
);
    logic [5:0] op;
    alu_op_t    r_alu;
    logic       unused_shamt;
    assign op           = ir[31:26];
    assign r_alu        = funct_alu(ir[5:0]);
    assign unused_shamt = ^ir[10:6];
    assign rsource      = ir[25:21];
    assign rtemp        = ir[20:16];
    assign rdestination = op == OP_RTYPE ? ir[15:11] : ir[20:16];
    assign imm          = ir[7:0];
    assign use_imm      = op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
    assign alu_op       = op == OP_RTYPE ? r_alu :
                          op == OP_ADDI  ? ALU_ADD :
                          op == OP_ANDI  ? ALU_AND :
                          op == OP_ORI   ? ALU_OR :
                          op == OP_BEQ   ? ALU_SUB : ALU_NOP;
    // unknown functs decode to NOP and must never write back
    assign is_wb        = (op == OP_RTYPE && r_alu != ALU_NOP) || use_imm;
    assign is_beq       = op == OP_BEQ;
    assign is_j         = op == OP_J;
    assign is_halt      = op == OP_HALT;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle IF/ID/RF/EX/WB control FSM owning pc, ir and the branch-taken flag
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int PC_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    control_sequencer_if.master bus
);
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc, pc_next, br_off;
    logic [31:0]     ir;
    logic            take_br;
    logic [4:0]      rs, rt, rd;
    alu_op_t         alu_op;
    logic            use_imm, is_wb, is_beq, is_j, is_halt;
    logic [7:0]      imm;

    instr_decode u_dec (
        .ir(ir), .rsource(rs), .rtemp(rt), .rdestination(rd), .alu_op(alu_op),
        .use_imm(use_imm), .imm(imm), .is_wb(is_wb), .is_beq(is_beq), .is_j(is_j), .is_halt(is_halt)
    );

    assign bus.imem_addr    = pc;
    assign bus.rsource      = rs;
    assign bus.rtemp        = rt;
    assign bus.rdestination = rd;
    assign bus.alu_op       = alu_op;
    assign bus.use_imm      = use_imm;
    assign bus.imm          = imm;

    // branch offset is the low immediate byte, sign-extended or truncated to the pc width
    assign br_off  = PC_W'($signed(imm));
    assign pc_next = is_j ? ir[PC_W-1:0] : take_br ? pc + PC_W'(1) + br_off : pc + PC_W'(1);

    always_ff @(posedge clk)
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;

    always_comb begin
        case (state_q)
            S_IF:    state_d = bus.run ? S_ID : S_IF;
            S_ID:    state_d = S_RF;
            S_RF:    state_d = is_halt ? S_OUT : S_EX;
            S_EX:    state_d = S_WB;
            S_WB:    state_d = S_IF;
            S_OUT:   state_d = S_OUT;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        bus.state  = state_q;
        bus.halted = state_q == S_OUT;
        bus.wb_en  = state_q == S_WB && is_wb && rd != 5'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            ir      <= '0;
            take_br <= 1'b0;
        end else begin
            if (state_q == S_ID) ir <= bus.imem_data;
            if (state_q == S_EX) take_br <= is_beq && bus.alu_zero;
            if (state_q == S_WB) pc <= pc_next;
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scoreboard bench for the multi-cycle control sequencer
module tb_control_sequencer;
    typedef struct {
        string       tag;
        logic [31:0] v;
    } item_t;

    logic        clk;
    logic        rst;
    logic [31:0] rom [256];
    item_t       sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    control_sequencer_if #(.PC_W(8)) bus ();
    control_sequencer #(.PC_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic want(input string tag, input logic [31:0] v);
        item_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic got(input logic [31:0] obs);
        item_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                n_bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    endtask

    task automatic reset_dut();
        bus.run      = 1'b0;
        bus.alu_zero = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.run      = 1'b0;
        bus.alu_zero = 1'b0;
        clear_rom();
        // reset mid-EX at pc=5, then idle with run low
        rom[0] = 32'h0800_0005;
        reset_dut();
        want("rst_state", 0); got(32'(bus.state));
        bus.run = 1'b1;
        run_n(5);
        want("j5_addr", 5); got(32'(bus.imem_addr));
        run_n(3);
        want("pre_rst_ex", 3); got(32'(bus.state));
        rst = 1'b1; bus.run = 1'b0;
        tick();
        rst = 1'b0;
        want("midex_state", 0); got(32'(bus.state));
        want("midex_pc", 0); got(32'(bus.imem_addr));
        want("midex_wb", 0); got(32'(bus.wb_en));
        want("midex_halted", 0); got(32'(bus.halted));
        for (int i = 0; i < 10; i++) begin
            want("idle_state", 0);
            tick();
            got(32'(bus.state));
        end
        want("idle_pc", 0); got(32'(bus.imem_addr));
        // ADD r3,r1,r2
        clear_rom(); rom[0] = 32'h0022_1820;
        reset_dut(); bus.run = 1'b1;
        want("add_s0", 0); got(32'(bus.state)); tick();
        want("add_s1", 1); got(32'(bus.state)); tick();
        want("add_s2", 2); want("add_rs", 1); want("add_rt", 2); want("add_rd", 3);
        want("add_op", 1); want("add_wb_rf", 0); want("add_imm", 0);
        got(32'(bus.state)); got(32'(bus.rsource)); got(32'(bus.rtemp)); got(32'(bus.rdestination));
        got(32'(bus.alu_op)); got(32'(bus.wb_en)); got(32'(bus.use_imm));
        tick();
        want("add_s3", 3); want("add_wb_ex", 0); got(32'(bus.state)); got(32'(bus.wb_en)); tick();
        want("add_s4", 4); want("add_wb_wb", 1); got(32'(bus.state)); got(32'(bus.wb_en)); tick();
        want("add_s_if", 0); want("add_wb_if", 0); want("add_pc", 1);
        got(32'(bus.state)); got(32'(bus.wb_en)); got(32'(bus.imem_addr));
        // ADDI r4,r0,7
        clear_rom(); rom[0] = 32'h2004_0007;
        reset_dut(); bus.run = 1'b1;
        run_n(2);
        want("addi_useimm", 1); want("addi_imm", 7); want("addi_rd", 4); want("addi_op", 1);
        got(32'(bus.use_imm)); got(32'(bus.imm)); got(32'(bus.rdestination)); got(32'(bus.alu_op));
        run_n(2);
        want("addi_s4", 4); want("addi_wb", 1); got(32'(bus.state)); got(32'(bus.wb_en));
        // ADD with rd=0 never writes back
        clear_rom(); rom[0] = 32'h0022_0020;
        reset_dut(); bus.run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            want("rd0_wb", 0);
            got(32'(bus.wb_en));
            tick();
        end
        want("rd0_pc", 1); got(32'(bus.imem_addr));
        // BEQ at pc=2 with offset -2, taken then not taken
        for (int t = 1; t >= 0; t--) begin
            clear_rom(); rom[2] = 32'h1022_FFFE;
            reset_dut(); bus.run = 1'b1;
            run_n(10);
            want("beq_at2", 2); got(32'(bus.imem_addr));
            run_n(2);
            want("beq_op", 2); want("beq_useimm", 0); want("beq_imm", 32'hFE);
            got(32'(bus.alu_op)); got(32'(bus.use_imm)); got(32'(bus.imm));
            tick();
            bus.alu_zero = t[0];
            want("beq_ex", 3); got(32'(bus.state));
            tick();
            bus.alu_zero = 1'b0;
            want("beq_wb", 0); got(32'(bus.wb_en));
            tick();
            want(t != 0 ? "beq_taken_pc" : "beq_fall_pc", t != 0 ? 1 : 3);
            got(32'(bus.imem_addr));
        end
        // pc wrap 255 -> 0
        clear_rom(); rom[0] = 32'h0800_00FF;
        reset_dut(); bus.run = 1'b1;
        run_n(5);
        want("wrap_255", 255); got(32'(bus.imem_addr));
        run_n(5);
        want("wrap_0", 0); got(32'(bus.imem_addr));
        // J 0x10 then unknown opcode 0x3B
        clear_rom(); rom[0] = 32'h0800_0010; rom[16] = 32'hEC22_1820;
        reset_dut(); bus.run = 1'b1;
        run_n(5);
        want("j16", 16); got(32'(bus.imem_addr));
        run_n(4);
        want("unk_s4", 4); want("unk_wb", 0); want("unk_op", 0);
        got(32'(bus.state)); got(32'(bus.wb_en)); got(32'(bus.alu_op));
        tick();
        want("unk_pc", 17); got(32'(bus.imem_addr));
        // HALT parks in OUTPUT regardless of run
        clear_rom(); rom[0] = 32'hFC00_0000;
        reset_dut(); bus.run = 1'b1;
        want("halt_s0", 0); got(32'(bus.state)); tick();
        want("halt_s1", 1); got(32'(bus.state)); tick();
        want("halt_s2", 2); got(32'(bus.state)); tick();
        want("halt_s5", 5); want("halt_flag", 1); got(32'(bus.state)); got(32'(bus.halted));
        for (int i = 0; i < 20; i++) begin
            bus.run = 1'($urandom_range(0, 1));
            want("park_state", 5); want("park_halted", 1); want("park_pc", 0);
            tick();
            got(32'(bus.state)); got(32'(bus.halted)); got(32'(bus.imem_addr));
        end
        reset_dut();
        want("unhalt_state", 0); want("unhalt_flag", 0); got(32'(bus.state)); got(32'(bus.halted));
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
